// File: rtl/peripheral_bus.sv
// Memory-mapped peripheral page at 0x40000000: reload timer, LED/switch/7-seg registers and 8N1 UART.
// Optional build macro PERIPH_SYSTICK_EN adds a free-running cycle counter readable at offset 0x24.
module peripheral_bus #(
    parameter int BAUD_DIV = 5208
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  led,
    input  logic [7:0]  switch,
    output logic [11:0] digi,
    output logic [1:0]  irqout,
    input  logic        UART_RX,
    output logic        UART_TX,
    input  logic        PC31
);
    localparam logic [25:0] PAGE = 26'h100_0000;
    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 2;
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic [31:0]   th_reg, tl_reg;
    logic [2:0]    tcon_reg;
    logic [7:0]    led_reg;
    logic [11:0]   digi_reg;
    logic [1:0]    con_en_reg;
    logic          rx_done_reg, tx_done_reg;

    logic          rx_meta_reg, rx_sync_reg;
    logic [1:0]    rx_state_reg;
    logic [CW-1:0] rx_cnt_reg;
    logic [2:0]    rx_bit_reg;
    logic [7:0]    rx_shift_reg, rxd_reg;

    logic          tx_busy_reg, tx_line_reg;
    logic [CW-1:0] tx_cnt_reg;
    logic [3:0]    tx_bit_reg;
    logic [8:0]    tx_shift_reg;
    logic [7:0]    txd_reg;

    logic       page_hit;
    logic [5:0] off;
    logic       wr_th, wr_tl, wr_tcon, wr_led, wr_digi, wr_txd, wr_con;
    logic       con_clr, tl_wrap, rx_event, tx_start, tx_finish;

    assign page_hit = (addr[31:6] == PAGE);
    assign off      = addr[5:0];
    assign wr_th    = wr && page_hit && (off == 6'h00);
    assign wr_tl    = wr && page_hit && (off == 6'h04);
    assign wr_tcon  = wr && page_hit && (off == 6'h08);
    assign wr_led   = wr && page_hit && (off == 6'h0C);
    assign wr_digi  = wr && page_hit && (off == 6'h14);
    assign wr_txd   = wr && page_hit && (off == 6'h18);
    assign wr_con   = wr && page_hit && (off == 6'h20);
    assign con_clr  = rd && page_hit && (off == 6'h20);

    assign tl_wrap   = (tl_reg == 32'hFFFF_FFFF);
    assign rx_event  = (rx_state_reg == RX_STOP) && (rx_cnt_reg == BIT_LAST) && rx_sync_reg;
    assign tx_start  = wr_txd && !tx_busy_reg;
    assign tx_finish = tx_busy_reg && (tx_cnt_reg == BIT_LAST) && (tx_bit_reg == 4'd9);

    assign led     = led_reg;
    assign digi    = digi_reg;
    assign UART_TX = tx_line_reg;
    assign irqout[0] = tcon_reg[2] & ~PC31;
    assign irqout[1] = ((rx_done_reg & con_en_reg[1]) | (tx_done_reg & con_en_reg[0])) & ~PC31;

`ifdef PERIPH_SYSTICK_EN
    logic [31:0] systick_reg;

    always_ff @(posedge clk) begin
        if (!reset) systick_reg <= '0;
        else        systick_reg <= systick_reg + 32'd1;
    end
`endif

    always_comb begin
        rdata = '0;
        if (rd && page_hit) begin
            case (off)
                6'h00: rdata = th_reg;
                6'h04: rdata = tl_reg;
                6'h08: rdata = {29'd0, tcon_reg};
                6'h0C: rdata = {24'd0, led_reg};
                6'h10: rdata = {24'd0, switch};
                6'h14: rdata = {20'd0, digi_reg};
                6'h18: rdata = {24'd0, txd_reg};
                6'h1C: rdata = {24'd0, rxd_reg};
                6'h20: rdata = {27'd0, tx_busy_reg, rx_done_reg, tx_done_reg, con_en_reg};
`ifdef PERIPH_SYSTICK_EN
                6'h24: rdata = systick_reg;
`endif
                default: rdata = '0;
            endcase
        end
    end

    // CPU writes to TL/TCON take precedence over the counter in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            th_reg   <= '0;
            tl_reg   <= '0;
            tcon_reg <= '0;
            led_reg  <= '0;
            digi_reg <= '0;
        end else begin
            if (wr_th)   th_reg   <= wdata;
            if (wr_led)  led_reg  <= wdata[7:0];
            if (wr_digi) digi_reg <= wdata[11:0];
            if (wr_tl)
                tl_reg <= wdata;
            else if (tcon_reg[0])
                tl_reg <= tl_wrap ? th_reg : tl_reg + 32'd1;
            if (wr_tcon)
                tcon_reg <= wdata[2:0];
            else if (tcon_reg[0] && tl_wrap && tcon_reg[1])
                tcon_reg[2] <= 1'b1;
        end
    end

    // A done event arriving together with a status read keeps the flag set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            con_en_reg  <= '0;
            rx_done_reg <= 1'b0;
            tx_done_reg <= 1'b0;
        end else begin
            if (wr_con) con_en_reg <= wdata[1:0];
            if (rx_event)     rx_done_reg <= 1'b1;
            else if (con_clr) rx_done_reg <= 1'b0;
            if (tx_finish)    tx_done_reg <= 1'b1;
            else if (con_clr) tx_done_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
            rxd_reg      <= '0;
        end else begin
            rx_meta_reg <= UART_RX;
            rx_sync_reg <= rx_meta_reg;
            case (rx_state_reg)
                RX_IDLE: begin
                    if (!rx_sync_reg) begin
                        rx_state_reg <= RX_START;
                        rx_cnt_reg   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_reg == HALF_LAST) begin
                        rx_cnt_reg   <= '0;
                        rx_bit_reg   <= '0;
                        rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_reg == BIT_LAST) begin
                        rx_cnt_reg   <= '0;
                        rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
                        rx_bit_reg   <= rx_bit_reg + 1'b1;
                        if (rx_bit_reg == 3'd7) rx_state_reg <= RX_STOP;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    // Stop bit sampled mid-bit; a low stop bit drops the byte silently.
                    if (rx_cnt_reg == BIT_LAST) begin
                        rx_cnt_reg   <= '0;
                        rx_state_reg <= RX_IDLE;
                        if (rx_sync_reg) rxd_reg <= rx_shift_reg;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_busy_reg  <= 1'b0;
            tx_line_reg  <= 1'b1;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            txd_reg      <= '0;
        end else if (tx_start) begin
            txd_reg      <= wdata[7:0];
            tx_shift_reg <= {1'b1, wdata[7:0]};
            tx_busy_reg  <= 1'b1;
            tx_line_reg  <= 1'b0;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
        end else if (tx_busy_reg) begin
            if (tx_cnt_reg == BIT_LAST) begin
                tx_cnt_reg <= '0;
                if (tx_bit_reg == 4'd9) begin
                    tx_busy_reg <= 1'b0;
                    tx_line_reg <= 1'b1;
                end else begin
                    tx_line_reg  <= tx_shift_reg[0];
                    tx_shift_reg <= {1'b1, tx_shift_reg[8:1]};
                    tx_bit_reg   <= tx_bit_reg + 1'b1;
                end
            end else begin
                tx_cnt_reg <= tx_cnt_reg + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_peripheral_bus.sv
// Directed bench for peripheral_bus: GPIO, timer, UART RX/TX, status clear and reset recovery.
module tb_peripheral_bus;
    localparam int B = 16;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd, wr;
    logic [31:0] addr, wdata, rdata;
    logic [7:0]  led, switch;
    logic [11:0] digi;
    logic [1:0]  irqout;
    logic        UART_RX, UART_TX, PC31;

    int total = 0;
    int bad   = 0;
    logic [39:0] rx_pat = 40'hFFFFA7FF96;
    logic [31:0] rv;

    peripheral_bus #(.BAUD_DIV(B)) dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .led(led), .switch(switch), .digi(digi), .irqout(irqout),
        .UART_RX(UART_RX), .UART_TX(UART_TX), .PC31(PC31)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic bus_write(input logic [31:0] offset, input logic [31:0] data);
        addr  = BASE + offset;
        wdata = data;
        wr    = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] offset, output logic [31:0] data);
        addr = BASE + offset;
        rd   = 1'b1;
        #1 data = rdata;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic check_read(input string tag, input logic [31:0] offset, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(offset, d);
        check(tag, d, exp);
    endtask

    task automatic send_frame(input logic [7:0] b);
        for (int k = 0; k < 10; k++) begin
            UART_RX = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            repeat (B) @(negedge clk);
        end
        UART_RX = 1'b1;
    endtask

    initial begin
        reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        PC31 = 1'b0; UART_RX = 1'b1; switch = 8'h3C;
        repeat (3) @(negedge clk);
        check("rst_uart_tx", UART_TX, 1);
        check("rst_irqout", irqout, 0);
        check("rst_led", led, 0);
        reset = 1'b1;
        @(negedge clk);
        check_read("rst_tl", 32'h04, 0);
        check_read("rst_con", 32'h20, 0);

        // GPIO
        bus_write(32'h0C, 32'hA5);
        check("led", led, 32'hA5);
        bus_write(32'h14, 32'hFFF3C);
        check("digi", digi, 32'hF3C);
        check_read("digi_rd", 32'h14, 32'hF3C);
        check_read("switch_rd", 32'h10, 32'h3C);
        check_read("unmapped_40", 32'h40, 0);
        addr = BASE + 32'h0C; rd = 1'b0;
        #1 check("rd_low", rdata, 0);
        @(negedge clk);
`ifdef PERIPH_SYSTICK_EN
        begin
            logic [31:0] s0, s1;
            bus_read(32'h24, s0);
            bus_read(32'h24, s1);
            check("systick_step", s1 - s0, 1);
        end
`else
        check_read("systick_off", 32'h24, 0);
`endif

        // Timer reload and interrupt
        bus_write(32'h00, 32'h10);
        bus_write(32'h04, 32'hFFFF_FFFE);
        bus_write(32'h08, 32'h3);
        repeat (2) @(negedge clk);
        check_read("tl_reload", 32'h04, 32'h10);
        check_read("tcon_irq", 32'h08, 32'h7);
        check("irq0_user", irqout[0], 1);
        PC31 = 1'b1;
        #1 check("irq0_kernel", irqout[0], 0);
        PC31 = 1'b0;
        @(negedge clk);
        bus_write(32'h08, 32'h3);
        check_read("tcon_clear", 32'h08, 32'h3);
        check("irq0_cleared", irqout[0], 0);
        bus_write(32'h04, 32'h5);
        check_read("tl_write_wins", 32'h04, 32'h5);
        bus_write(32'h08, 32'h0);

        // UART RX: cyclic 40-bit pattern, two rounds
        for (int i = 0; i < 80; i++) begin
            int used;
            used = 0;
            UART_RX = rx_pat[i % 40];
            if (i % 40 == 12) begin
                check_read("rxd_cb", 32'h1C, 32'hCB);
                check_read("rx_done_cb", 32'h20, 32'h08);
                used = 2;
            end else if (i % 40 == 25) begin
                check_read("rx_done_low", 32'h20, 32'h00);
                used = 1;
            end else if (i % 40 == 32) begin
                check_read("rxd_fa", 32'h1C, 32'hFA);
                used = 1;
                if (i < 40) begin
                    check_read("rx_done_fa", 32'h20, 32'h08);
                    used = 2;
                end
            end
            repeat (B - used) @(negedge clk);
        end
        UART_RX = 1'b1;

        // Status clear by reading UART_CON
        for (int j = 0; j < 5; j++)
            check_read("con_clear", 32'h20, (j == 0) ? 32'h08 : 32'h00);
        check_read("rxd_hold", 32'h1C, 32'hFA);

        // UART TX 0x55
        bus_write(32'h20, 32'h1);
        bus_write(32'h18, 32'h55);
        repeat (B/2 - 1) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            int used;
            used = 0;
            check("tx_bit", UART_TX, k % 2);
            if (k == 2) begin
                bus_write(32'h18, 32'hFF);
                used = 1;
            end else if (k == 3) begin
                check_read("tx_busy", 32'h20, 32'h11);
                used = 1;
            end else if (k == 4) begin
                check_read("txd_kept", 32'h18, 32'h55);
                used = 1;
            end
            if (k < 9) repeat (B - used) @(negedge clk);
        end
        repeat (B/2 + 1) @(negedge clk);
        check("tx_idle", UART_TX, 1);
        check("irq1_tx", irqout[1], 1);
        check_read("tx_done", 32'h20, 32'h05);
        check("irq1_cleared", irqout[1], 0);

        // Reset mid-TX and mid-RX
        bus_write(32'h00, 32'h123);
        bus_write(32'h04, 32'h77);
        bus_write(32'h08, 32'h6);
        bus_write(32'h20, 32'h3);
        check("irq0_pre_rst", irqout[0], 1);
        bus_write(32'h18, 32'h0F);
        UART_RX = 1'b0;
        repeat (B + B/2) @(negedge clk);
        reset = 1'b0;
        UART_RX = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        check("mid_rst_tx", UART_TX, 1);
        check("mid_rst_irq", irqout, 0);
        check("mid_rst_led", led, 0);
        check("mid_rst_digi", digi, 0);
        check_read("mid_rst_th", 32'h00, 0);
        check_read("mid_rst_tl", 32'h04, 0);
        check_read("mid_rst_tcon", 32'h08, 0);
        check_read("mid_rst_txd", 32'h18, 0);
        check_read("mid_rst_rxd", 32'h1C, 0);
        repeat (2 * B) @(negedge clk);
        check("post_rst_tx", UART_TX, 1);
        check_read("post_rst_con", 32'h20, 0);
        send_frame(8'h3C);
        repeat (B) @(negedge clk);
        check_read("rxd_after_rst", 32'h1C, 32'h3C);
        check_read("rx_done_after_rst", 32'h20, 32'h08);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
